// File: rtl/plfsr_pkg.sv
// Shared types and the single-step LFSR function for parallel_lfsr_stream.
// The optional beat counter is built only when PLFSR_BEAT_CNT_EN is defined.
package plfsr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_BURST
   } plfsr_state_t;

   localparam logic [7:0] LFSR_P_DEF = 8'h8E;
   localparam logic [7:0] LFSR_R_DEF = 8'hC3;

   // One Fibonacci step on a zero-extended state of width n (n <= 64).
   function automatic logic [63:0] lfsr_step(
      input logic [63:0] s,
      input logic [63:0] p,
      input int          n
   );
      logic [63:0] m;
      logic        fb;
      fb = ^(s & p);
      m  = '1;
      if (n < 64) m = (64'd1 << n) - 64'd1;
      return {s[62:0], fb} & m;
   endfunction

endpackage

// File: rtl/plfsr_unroll.sv
// Combinational M-deep unroll of lfsr_step: word k is X advanced k+1 steps.
// Used by parallel_lfsr_stream (optional macro PLFSR_BEAT_CNT_EN has no effect here).
module plfsr_unroll
   import plfsr_pkg::*;
#(
   parameter int LFSR_N = 8,
   parameter int LFSR_M = 4
) (
   input  logic [LFSR_N-1:0]        i_x,
   input  logic [LFSR_N-1:0]        i_poly,
   output logic [LFSR_M*LFSR_N-1:0] o_gen
);

   logic [63:0] w_v;

   always_comb begin
      w_v   = 64'(i_x);
      o_gen = '0;
      for (int k = 0; k < LFSR_M; k++) begin
         w_v = lfsr_step(w_v, 64'(i_poly), LFSR_N);
         o_gen[k*LFSR_N +: LFSR_N] = w_v[LFSR_N-1:0];
      end
   end

endmodule

// File: rtl/parallel_lfsr_stream.sv
// Parallel Fibonacci LFSR source with valid/ready, counted bursts and lock-up guard.
// Define PLFSR_BEAT_CNT_EN to build the saturating accepted-beat counter.
module parallel_lfsr_stream
   import plfsr_pkg::*;
#(
   parameter int                LFSR_N  = 8,
   parameter int                LFSR_M  = 4,
   parameter logic [LFSR_N-1:0] LFSR_P  = LFSR_P_DEF,
   parameter logic [LFSR_N-1:0] LFSR_R  = LFSR_R_DEF,
   parameter int                BURST_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_LFSR_enable,
   input  logic                     i_LFSR_load,
   input  logic [LFSR_N-1:0]        i_LFSR_seed,
   input  logic [LFSR_N-1:0]        i_LFSR_poly,
   input  logic                     i_burst_start,
   input  logic [BURST_W-1:0]       i_burst_len,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [LFSR_M*LFSR_N-1:0] o_LFSR_val,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_lockup_err,
   output logic [31:0]              o_beat_cnt
);

   localparam int W = LFSR_M * LFSR_N;

   plfsr_state_t        r_state, w_nstate;
   logic [LFSR_N-1:0]   r_seed, w_nseed;
   logic [LFSR_N-1:0]   r_poly, w_npoly;
   logic [W-1:0]        r_data, w_ndata;
   logic [BURST_W-1:0]  r_rem, w_nrem;
   logic                r_valid, w_nvalid;
   logic                r_done, w_ndone;
   logic                r_lock, w_nlock;

   logic [LFSR_N-1:0]   w_last;
   logic [LFSR_N-1:0]   w_src;
   logic [W-1:0]        w_gen;
   logic                w_accept;

   assign w_last   = r_data[(LFSR_M-1)*LFSR_N +: LFSR_N];
   assign w_src    = (r_state == ST_IDLE) ? r_seed : w_last;
   // A load on the same edge discards the beat, so it is not an accept.
   assign w_accept = r_valid & i_ready & ~i_LFSR_load;

   plfsr_unroll #(
      .LFSR_N (LFSR_N),
      .LFSR_M (LFSR_M)
   ) u_unroll (
      .i_x    (w_src),
      .i_poly (r_poly),
      .o_gen  (w_gen)
   );

   always_comb begin
      w_nstate = r_state;
      w_nseed  = r_seed;
      w_npoly  = r_poly;
      w_ndata  = r_data;
      w_nrem   = r_rem;
      w_nvalid = r_valid;
      w_ndone  = 1'b0;
      w_nlock  = r_lock;
      if (i_LFSR_load) begin
         w_nstate = ST_IDLE;
         w_nvalid = 1'b0;
         w_nseed  = i_LFSR_seed;
         w_npoly  = i_LFSR_poly;
         if (i_LFSR_seed == '0) begin
            w_nseed = LFSR_R;
            w_nlock = 1'b1;
         end
         if (i_LFSR_poly == '0) begin
            w_npoly = LFSR_P;
            w_nlock = 1'b1;
         end
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_burst_start && (i_burst_len != '0)) begin
                  w_ndata  = w_gen;
                  w_nrem   = i_burst_len;
                  w_nstate = ST_BURST;
                  w_nvalid = 1'b1;
               end else if (i_LFSR_enable) begin
                  w_ndata  = w_gen;
                  w_nstate = ST_STREAM;
                  w_nvalid = 1'b1;
               end
            end
            ST_STREAM: begin
               if (w_accept) begin
                  if (i_LFSR_enable) begin
                     w_ndata = w_gen;
                  end else begin
                     w_nstate = ST_IDLE;
                     w_nvalid = 1'b0;
                     w_nseed  = w_last;
                  end
               end
            end
            ST_BURST: begin
               if (w_accept) begin
                  if (r_rem == BURST_W'(1)) begin
                     w_ndone  = 1'b1;
                     w_nstate = ST_IDLE;
                     w_nvalid = 1'b0;
                     w_nseed  = w_last;
                  end else begin
                     w_nrem  = r_rem - BURST_W'(1);
                     w_ndata = w_gen;
                  end
               end
            end
            default: begin
               w_nstate = ST_IDLE;
               w_nvalid = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_seed  <= LFSR_R;
         r_poly  <= LFSR_P;
         r_data  <= '0;
         r_rem   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_lock  <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_seed  <= w_nseed;
         r_poly  <= w_npoly;
         r_data  <= w_ndata;
         r_rem   <= w_nrem;
         r_valid <= w_nvalid;
         r_done  <= w_ndone;
         r_lock  <= w_nlock;
      end
   end

`ifdef PLFSR_BEAT_CNT_EN
   logic [31:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (w_accept && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_beat_cnt = r_cnt;
`else
   assign o_beat_cnt = '0;
`endif

   assign o_valid      = r_valid;
   assign o_LFSR_val   = r_data;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_done       = r_done;
   assign o_lockup_err = r_lock;

endmodule
